// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, default parameter values and the saturating
//               counter step function for the branch predictor table.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Default parameter values for branch_predictor_table
  localparam int BP_IDX_W     = 6;
  localparam int BP_CNT_W     = 2;
  localparam int BP_HIST_W    = 0;
  localparam int BP_INIT      = (1 << BP_CNT_W) - 1;
  localparam int BP_STAT_W    = 16;

  // Widest counter the step function has to handle
  localparam int BP_CNT_MAX_W = 4;

  // Controller states: S_INIT sweeps the table, S_RUN serves traffic
  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bp_state_e;

  // Next value of a cnt_w-bit saturating counter; clamps at 0 and 2^cnt_w-1
  function automatic logic [BP_CNT_MAX_W-1:0] sat_next(
    input logic [BP_CNT_MAX_W-1:0] cnt,
    input logic                    taken,
    input int                      cnt_w
  );
    logic [BP_CNT_MAX_W-1:0] max_v;
    max_v = BP_CNT_MAX_W'((1 << cnt_w) - 1);
    if (taken) begin
      return (cnt >= max_v) ? max_v : cnt + BP_CNT_MAX_W'(1);
    end
    return (cnt == '0) ? '0 : cnt - BP_CNT_MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter_update.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter_update
// Description : Combinational saturating up/down step for one table counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_update
  import bp_pkg::*;
#(
  parameter int CNT_W = BP_CNT_W
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_taken,
  output logic [CNT_W-1:0] o_next
);

  logic [BP_CNT_MAX_W-1:0] w_cnt_ext;
  logic [BP_CNT_MAX_W-1:0] w_next_ext;
  logic                    w_unused_bits;

  // Widen to the function's fixed width, step, then narrow back
  assign w_cnt_ext     = BP_CNT_MAX_W'(i_cnt);
  assign w_next_ext    = sat_next(w_cnt_ext, i_taken, CNT_W);
  assign o_next        = w_next_ext[CNT_W-1:0];
  // Upper bits are always zero for narrow counters
  assign w_unused_bits = ^w_next_ext;

endmodule
`default_nettype wire

// File: rtl/branch_predictor_table.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_table
// Description : Table of saturating counters giving bimodal or gshare branch
//               direction predictions, with self-initialisation sweep,
//               flush, and update / misprediction statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int IDX_W  = BP_IDX_W,
  parameter int CNT_W  = BP_CNT_W,
  parameter int HIST_W = BP_HIST_W,
  parameter int INIT   = (1 << CNT_W) - 1,
  parameter int STAT_W = BP_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              ready,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int                DEPTH      = 1 << IDX_W;
  localparam logic [CNT_W-1:0]  c_init_val = CNT_W'(INIT);
  localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(DEPTH - 1);
  localparam logic [STAT_W-1:0] c_stat_max = '1;

  bp_state_e         r_state;
  logic [IDX_W-1:0]  r_sweep;
  logic [CNT_W-1:0]  r_table [DEPTH];
  logic              r_pred_valid;
  logic              r_pred_taken;
  logic [IDX_W-1:0]  r_pred_idx;
  logic [STAT_W-1:0] r_stat_upd;
  logic [STAT_W-1:0] r_stat_mis;

  logic              w_run;
  logic              w_req_en;
  logic              w_upd_en;
  logic [IDX_W-1:0]  w_hist_ext;
  logic [IDX_W-1:0]  w_req_idx;
  logic [CNT_W-1:0]  w_req_cnt;
  logic [CNT_W-1:0]  w_upd_cnt;
  logic [CNT_W-1:0]  w_upd_next;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [CNT_W-1:0]  w_wdata;

  // Traffic is accepted only in RUN; a flush in the same cycle discards it
  assign w_run     = (r_state == S_RUN);
  assign w_req_en  = w_run & req_valid & ~flush;
  assign w_upd_en  = w_run & upd_valid & ~flush;

  // Both read ports see the table as it was before this edge (no bypass)
  assign w_req_idx = req_pc ^ w_hist_ext;
  assign w_req_cnt = r_table[w_req_idx];
  assign w_upd_cnt = r_table[upd_idx];

  // Single write port shared by the INIT sweep and the RUN update
  assign w_we      = ~w_run | w_upd_en;
  assign w_waddr   = w_run ? upd_idx : r_sweep;
  assign w_wdata   = w_run ? w_upd_next : c_init_val;

  sat_counter_update #(
    .CNT_W (CNT_W)
  ) u_sat_update (
    .i_cnt   (w_upd_cnt),
    .i_taken (upd_taken),
    .o_next  (w_upd_next)
  );

  generate
    if (HIST_W > 0) begin : g_gshare
      logic [HIST_W-1:0] r_hist;

      // Global history: shift in each resolved direction at the LSB
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hist <= '0;
        end else if (flush) begin
          r_hist <= '0;
        end else if (w_upd_en) begin
          r_hist <= HIST_W'({r_hist, upd_taken});
        end
      end

      assign w_hist_ext = IDX_W'(r_hist);
    end else begin : g_bimodal
      assign w_hist_ext = '0;
    end
  endgenerate

  // Counter storage: no reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_table[w_waddr] <= w_wdata;
    end
  end

  // Controller: INIT sweep / RUN, plus the registered prediction response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_sweep      <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else if (flush) begin
      r_state      <= S_INIT;
      r_sweep      <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      r_pred_valid <= w_req_en;
      if (w_req_en) begin
        r_pred_taken <= w_req_cnt[CNT_W-1];
        r_pred_idx   <= w_req_idx;
      end
      if (r_state == S_INIT) begin
        r_sweep <= r_sweep + IDX_W'(1);
        if (r_sweep == c_last_idx) begin
          r_state <= S_RUN;
        end
      end
    end
  end

  // Saturating update and misprediction counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else if (flush) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else if (w_upd_en) begin
      if (r_stat_upd != c_stat_max) begin
        r_stat_upd <= r_stat_upd + STAT_W'(1);
      end
      if ((upd_taken != upd_pred) && (r_stat_mis != c_stat_max)) begin
        r_stat_mis <= r_stat_mis + STAT_W'(1);
      end
    end
  end

  assign ready        = w_run;
  assign pred_valid   = r_pred_valid;
  assign pred_taken   = r_pred_taken;
  assign pred_idx     = r_pred_idx;
  assign stat_updates = r_stat_upd;
  assign stat_mispred = r_stat_mis;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_table
// Description : Bench for branch_predictor_table. Three instances share the
//               stimulus: bimodal (a), gshare HIST_W=2 (g), STAT_W=2 (s).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_table;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       req_valid;
  logic [3:0] req_pc;
  logic       upd_valid;
  logic [3:0] upd_idx;
  logic       upd_taken;
  logic       upd_pred;

  logic        a_ready, a_pv, a_pt;
  logic [3:0]  a_pi;
  logic [15:0] a_su, a_sm;
  logic        g_ready, g_pv, g_pt;
  logic [3:0]  g_pi;
  logic [15:0] g_su, g_sm;
  logic        s_ready, s_pv, s_pt;
  logic [3:0]  s_pi;
  logic [1:0]  s_su, s_sm;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  branch_predictor_table #(
    .IDX_W(4), .CNT_W(2), .HIST_W(0), .INIT(3), .STAT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .ready(a_ready),
    .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(a_pv), .pred_taken(a_pt), .pred_idx(a_pi),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .stat_updates(a_su), .stat_mispred(a_sm)
  );

  branch_predictor_table #(
    .IDX_W(4), .CNT_W(2), .HIST_W(2), .INIT(3), .STAT_W(16)
  ) dut_g (
    .clk(clk), .rst(rst), .flush(flush), .ready(g_ready),
    .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(g_pv), .pred_taken(g_pt), .pred_idx(g_pi),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .stat_updates(g_su), .stat_mispred(g_sm)
  );

  branch_predictor_table #(
    .IDX_W(4), .CNT_W(2), .HIST_W(0), .INIT(3), .STAT_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .ready(s_ready),
    .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(s_pv), .pred_taken(s_pt), .pred_idx(s_pi),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .stat_updates(s_su), .stat_mispred(s_sm)
  );

  // Reference model: one behavioural copy per instance
  int m_tbl   [3][DEPTH];
  bit m_run   [3];
  int m_sweep [3];
  int m_hist  [3];
  int m_upd   [3];
  int m_mis   [3];
  bit e_pv    [3];
  int e_pt    [3];
  int e_pi    [3];

  function automatic int hist_len(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int stat_max(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 1'b0; m_sweep[k] = 0; m_hist[k] = 0;
      m_upd[k] = 0;    m_mis[k] = 0;
      e_pv[k] = 1'b0;  e_pt[k] = 0;   e_pi[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    int cnt;
    for (int k = 0; k < 3; k++) begin
      if (flush) begin
        m_run[k] = 1'b0; m_sweep[k] = 0; m_hist[k] = 0;
        m_upd[k] = 0;    m_mis[k] = 0;   e_pv[k] = 1'b0;
      end else if (!m_run[k]) begin
        m_tbl[k][m_sweep[k]] = 3;
        if (m_sweep[k] == DEPTH - 1) begin
          m_run[k] = 1'b1;
          m_sweep[k] = 0;
        end else begin
          m_sweep[k]++;
        end
        e_pv[k] = 1'b0;
      end else begin
        e_pv[k] = req_valid;
        if (req_valid) begin
          e_pi[k] = int'(req_pc) ^ m_hist[k];
          e_pt[k] = (m_tbl[k][e_pi[k]] >= 2) ? 1 : 0;
        end
        if (upd_valid) begin
          cnt = m_tbl[k][upd_idx];
          if (upd_taken) cnt = (cnt + 1 > 3) ? 3 : cnt + 1;
          else           cnt = (cnt - 1 < 0) ? 0 : cnt - 1;
          m_tbl[k][upd_idx] = cnt;
          m_hist[k] = (m_hist[k] * 2 + int'(upd_taken)) % (1 << hist_len(k));
          if (m_upd[k] < stat_max(k)) m_upd[k]++;
          if (upd_taken != upd_pred && m_mis[k] < stat_max(k)) m_mis[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic        rd, pv, pt;
    logic [31:0] pi, su, sm;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin rd = a_ready; pv = a_pv; pt = a_pt; pi = 32'(a_pi); su = 32'(a_su); sm = 32'(a_sm); end
        1: begin rd = g_ready; pv = g_pv; pt = g_pt; pi = 32'(g_pi); su = 32'(g_su); sm = 32'(g_sm); end
        default: begin rd = s_ready; pv = s_pv; pt = s_pt; pi = 32'(s_pi); su = 32'(s_su); sm = 32'(s_sm); end
      endcase
      chk($sformatf("ready[%0d]", k), 32'(rd), 32'(m_run[k]));
      chk($sformatf("pred_valid[%0d]", k), 32'(pv), 32'(e_pv[k]));
      if (e_pv[k]) begin
        chk($sformatf("pred_taken[%0d]", k), 32'(pt), 32'(e_pt[k]));
        chk($sformatf("pred_idx[%0d]", k), pi, 32'(e_pi[k]));
      end
      chk($sformatf("stat_updates[%0d]", k), su, 32'(m_upd[k]));
      chk($sformatf("stat_mispred[%0d]", k), sm, 32'(m_mis[k]));
    end
  endtask

  task automatic check_reset_state();
    check_all();
    chk("rst_pred_taken_a", 32'(a_pt), 0);
    chk("rst_pred_idx_a", 32'(a_pi), 0);
    chk("rst_pred_idx_g", 32'(g_pi), 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset is applied between edges so the asynchronous clear is observed
  task automatic hold_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check_reset_state();
    @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int first, input int exp_cycles);
    int cyc;
    cyc = first;
    while (a_ready !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    chk(tag, 32'(cyc), 32'(exp_cycles));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_pc = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;
    #1;

    // Reset release: ready after 16 cycles, fresh entry predicts taken
    hold_reset();
    wait_ready("ready_latency", 0, 16);
    req_valid = 1'b1; req_pc = 4'd5;
    step();
    req_valid = 1'b0;
    chk("first_pred_valid", 32'(a_pv), 1);
    chk("first_pred_taken", 32'(a_pt), 1);
    chk("first_pred_idx", 32'(a_pi), 5);

    // Saturation low then high on index 5
    upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b0; upd_pred = 1'b1;
    repeat (4) step();
    upd_valid = 1'b0; req_valid = 1'b1; req_pc = 4'd5;
    step();
    req_valid = 1'b0;
    chk("sat_low_taken", 32'(a_pt), 0);
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pred = 1'b0;
    repeat (5) step();
    upd_valid = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sat_high_taken", 32'(a_pt), 1);
    upd_valid = 1'b1; upd_taken = 1'b0; upd_pred = 1'b1;
    step();
    upd_valid = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sat_high_minus1", 32'(a_pt), 1);

    // Same-cycle request and update on index 7: no bypass
    upd_valid = 1'b1; upd_idx = 4'd7; upd_taken = 1'b0; upd_pred = 1'b1;
    req_valid = 1'b1; req_pc = 4'd7;
    step();
    upd_valid = 1'b0;
    chk("same_idx_old_value", 32'(a_pt), 1);
    step();
    req_valid = 1'b0;
    chk("same_idx_after", 32'(a_pt), 1);

    // Gshare: two taken updates give history 3, so pc 4 maps to index 7
    upd_valid = 1'b1; upd_idx = 4'd1; upd_taken = 1'b1; upd_pred = 1'b1;
    repeat (2) step();
    upd_valid = 1'b0; req_valid = 1'b1; req_pc = 4'd4;
    step();
    req_valid = 1'b0;
    chk("gshare_idx", 32'(g_pi), 7);
    chk("bimodal_idx", 32'(a_pi), 4);

    // Flush with a simultaneous update: update dropped, 16-cycle re-init
    flush = 1'b1; upd_valid = 1'b1; upd_idx = 4'd2; upd_taken = 1'b0; upd_pred = 1'b1;
    step();
    flush = 1'b0; upd_valid = 1'b0;
    chk("flush_ready_low", 32'(a_ready), 0);
    chk("flush_stat_upd", 32'(a_su), 0);
    chk("flush_stat_mis", 32'(a_sm), 0);
    wait_ready("flush_ready_latency", 0, 16);
    chk("flush_upd_dropped", 32'(a_su), 0);

    // Statistics saturation on the 2-bit instance
    upd_valid = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1; upd_pred = 1'b0;
    repeat (5) step();
    upd_valid = 1'b0;
    chk("stat2_updates_sat", 32'(s_su), 3);
    chk("stat2_mispred_sat", 32'(s_sm), 3);
    chk("stat16_updates", 32'(a_su), 5);
    chk("stat16_mispred", 32'(a_sm), 5);

    // Reset mid-traffic with a request in flight and one still asserted
    req_valid = 1'b1; req_pc = 4'd3;
    step();
    hold_reset();
    req_valid = 1'b0;
    wait_ready("reset_ready_latency", 0, 16);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_pc    = 4'($urandom);
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_idx   = 4'($urandom);
      upd_taken = 1'($urandom_range(0, 1));
      upd_pred  = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 79) == 0);
      step();
    end
    req_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
